// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encodings and GF(2^8) helpers used by the
// cipher core and the key-schedule stage.
package aes_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned BLOCK_W = 128;

  // Encoding is chosen so that busy and out_valid are single state bits.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ROUND = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte i of the block sits at [127-8i -: 8], column-major.
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               last,
  output logic [BLOCK_W-1:0] next_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = sbox(state[BLOCK_W-1-8*i -: 8]);
    end
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[r+4*c] = sb[r+4*((c+r)%4)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    next_state = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      next_state[BLOCK_W-1-8*i -: 8] = (last ? sr[i] : mc[i]) ^ round_key[BLOCK_W-1-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys taken
// from the upstream key schedule, valid/ready handshakes on both sides.
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          key,
  input  logic [NR*128-1:0]     round_keys,
  input  logic                  keys_valid,
  input  logic [127:0]          in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [127:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_cipher_core supports only NR = 10 (AES-128)");
  end

  logic [1:0]         state_q;
  logic [3:0]         round_q;
  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] rk;
  logic [BLOCK_W-1:0] round_out;

  always_comb begin
    rk = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      if (round_q == 4'(i)) rk = round_keys[NR*BLOCK_W-1-BLOCK_W*(i-1) -: BLOCK_W];
    end
  end

  aes_round u_round (
    .state      (data_q),
    .round_key  (rk),
    .last       (round_q == 4'(NR)),
    .next_state (round_out)
  );

  assign in_ready  = (state_q == S_IDLE) && keys_valid;
  assign busy      = state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            data_q  <= in_data ^ key;
            round_q <= 4'd1;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          data_q <= round_out;
          if (round_q == 4'(NR)) begin
            round_q <= '0;
            state_q <= S_DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboard bench for aes_cipher_core using FIPS-197 known-answer vectors.
module tb_aes_cipher_core;
  import aes_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  key;
  logic [1279:0] round_keys;
  logic          keys_valid;
  logic [127:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  logic [127:0]  sb [$];
  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  always #5 clk = ~clk;

  aes_cipher_core #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .round_keys (round_keys),
    .keys_valid (keys_valid),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1279:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1279:0] rks;
    rcon = 8'h01;
    rks  = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++) begin
      rks[1279-128*(r-1) -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return rks;
  endfunction

  task automatic load_key(input logic [127:0] k);
    key        = k;
    round_keys = expand(k);
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic send(input string tag, input logic [127:0] pt, input logic [127:0] ct);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = pt;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(ct);
    #1 in_valid = 1'b0;
  endtask

  // pre = edges already consumed since the edge after accept.
  task automatic collect(input string tag, input int unsigned pre);
    int unsigned  edges = 0;
    logic [127:0] exp;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    if (!out_valid) return;
    check({tag, "_latency"}, pre + edges + 1, 11);
    check({tag, "_pending"}, sb.size(), 1);
    if (sb.size() == 0) return;
    exp = sb.pop_front();
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic handshake_edge(input string tag);
    @(posedge clk); #1;
    check({tag, "_valid_fall"}, out_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst        = 1'b1;
    keys_valid = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    load_key(KEY_B);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready_kv0", in_ready, 0);
    keys_valid = 1'b1;
    #1 check("rst_in_ready_kv1", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    send("fips_b", PT_B, CT_B);
    check("fips_b_busy", busy, 1);
    check("fips_b_ready_low", in_ready, 0);
    collect("fips_b", 0);
    handshake_edge("fips_b");

    load_key(KEY_C);
    send("fips_c1", PT_C, CT_C);
    collect("fips_c1", 0);
    handshake_edge("fips_c1");

    load_key(KEY_B);
    out_ready = 1'b0;
    send("bp", PT_B, CT_B);
    collect("bp", 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, CT_B);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    handshake_edge("bp");

    send("ign", PT_B, CT_B);
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = PT_C;
    check("ign_in_ready", in_ready, 0);
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    collect("ign", 5);
    handshake_edge("ign");
    repeat (3) begin
      @(posedge clk); #1;
      check("ign_no_extra_valid", out_valid, 0);
      check("ign_no_extra_busy", busy, 0);
    end

    keys_valid = 1'b0;
    in_valid   = 1'b1;
    in_data    = PT_B;
    repeat (3) begin
      @(posedge clk); #1;
      check("kv_low_in_ready", in_ready, 0);
      check("kv_low_busy", busy, 0);
    end
    keys_valid = 1'b1;
    #1 check("kv_high_in_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back(CT_B);
    #1 in_valid = 1'b0;
    check("kv_accept_busy", busy, 1);
    collect("kv", 0);
    handshake_edge("kv");

    load_key(KEY_C);
    send("rst_mid", PT_C, CT_C);
    repeat (4) begin @(posedge clk); #1; end
    check("rst_mid_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out_data", out_data, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    load_key(KEY_B);
    send("post_rst", PT_B, CT_B);
    collect("post_rst", 0);
    handshake_edge("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
